alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
- REQ-001: Parameter WIDTH, default 16, operand and result width.
- REQ-002: Parameter ALU_LAT, default 1, cycles from ALU input sample to valid alu_out/alu_status; legal range 1..7.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: rst  input  1  reset, synchronous and active-high.
- REQ-005: req0_valid / req1_valid  input  1 each  requester N has an operation pending.
- REQ-006: req0_ready / req1_ready  output  1 each  arbiter accepts requester N's operation this cycle.
- REQ-007: req0_func / req1_func  input  4 each  ALU function code, passed through unmodified.
- REQ-008: req0_a, req0_b / req1_a, req1_b  input  WIDTH each  operands.
- REQ-009: rsp0_valid / rsp1_valid  output  1 each  result for requester N is available.
- REQ-010: rsp0_ready / rsp1_ready  input  1 each  requester N consumes the result.
- REQ-011: rsp_data  output  WIDTH  captured ALU result, shared by both response channels.
- REQ-012: rsp_status  output  8  captured ALU status register.
- REQ-013: alu_a, alu_b  output  WIDTH each; alu_func  output  4; alu_imm  output  1, driven 0; alu_imm_val  output  WIDTH, driven 0.
- REQ-014: alu_out  input  WIDTH; alu_status  input  8; driven by the shared ALU16bit instance.
- REQ-015: busy  output  1  high in every state except IDLE.

Function
- REQ-016: FSM states IDLE, ISSUE, WAIT, RESP; one operation in flight at a time.
- REQ-017: In IDLE, grant goes to the only valid requester; if both are valid, to the requester not granted last (round-robin).
- REQ-018: reqN_ready is high only in IDLE and only for the granted requester; at most one ready is high per cycle.
- REQ-019: On acceptance (reqN_valid & reqN_ready), func, a, b and the grant index are latched and the FSM enters ISSUE.
- REQ-020: alu_a, alu_b, alu_func carry the latched values from ISSUE through the last WAIT cycle, and hold their last value in all other states.
- REQ-021: ISSUE lasts 1 cycle; WAIT lasts exactly ALU_LAT cycles, counted by a 3-bit down-counter.
- REQ-022: At the end of the last WAIT cycle, alu_out goes to rsp_data and alu_status to rsp_status, and the FSM enters RESP.
- REQ-023: Latency: accept in cycle T gives rspN_valid high in cycle T+2+ALU_LAT (T+3 at default).
- REQ-024: In RESP, only the granted requester's rspN_valid is high; rsp_data and rsp_status are stable until the handshake.
- REQ-025: rspN_valid & rspN_ready in RESP: return to IDLE next cycle and update the last-grant register; no acceptance occurs in that same cycle.
- REQ-026: rspN_ready low: remain in RESP indefinitely; new requests get no ready and wait.
- REQ-027: reqN_valid deasserted before acceptance: the request is not latched and no error is flagged.
- REQ-028: Back-to-back throughput with a zero-wait consumer: one operation per 3+ALU_LAT cycles.

Reset
- REQ-029: While rst is high, state = IDLE, last-grant = requester 1 (so requester 0 wins the first tie), and counter = 0.
- REQ-030: While rst is high, all ready/valid outputs = 0, busy = 0, and rsp_data, rsp_status, alu_a, alu_b, alu_func = 0.
- REQ-031: rst asserted in any state aborts the in-flight operation with no response; the first acceptance can occur in the first cycle after rst is deasserted.

Verification
The bench uses a behavioral ALU: func 0 = a+b, latency 1, status = {7'b0, zero}.
- REQ-032: Single op: req0 func=0, a=4, b=3, accepted at T -> rsp0_valid at T+3, rsp_data=7, rsp_status=8'h00.
- REQ-033: Tie after reset: both valid (req0 a=5,b=5; req1 a=2,b=6) -> req0 served first (data=10), then req1 (data=8).
- REQ-034: Sustained contention, 4 ops per requester -> grants strictly alternate 0,1,0,1...; no starvation.
- REQ-035: Backpressure: rsp0_ready held low 5 cycles -> rsp0_valid and rsp_data stay stable; req1 gets no ready until the handshake.
- REQ-036: Zero status: a=0, b=0 -> rsp_data=0, rsp_status=8'h01.
- REQ-037: rst pulsed during WAIT -> no rspN_valid; the next request completes normally at T+3.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if -- requester-facing bus of the two-port ALU arbiter.
//
// Signals (master = requester side, slave = arbiter side):
//   reqN_valid  m->s  requester N has an operation pending
//   reqN_ready  s->m  arbiter accepts requester N's operation this cycle
//   reqN_func   m->s  4-bit ALU function code
//   reqN_a/b    m->s  WIDTH-bit operands
//   rspN_valid  s->m  result for requester N is available
//   rspN_ready  m->s  requester N consumes the result
//   rsp_data    s->m  captured ALU result, shared by both response channels
//   rsp_status  s->m  captured 8-bit ALU status, shared by both channels
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_func;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_func;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [7:0]       rsp_status;

  modport master (
    output req0_valid, req0_func, req0_a, req0_b,
    output req1_valid, req1_func, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_status
  );

  modport slave (
    input  req0_valid, req0_func, req0_a, req0_b,
    input  req1_valid, req1_func, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_status
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter -- shares one pipelined ALU between two requesters.
//
// One operation is in flight at a time. In IDLE the arbiter grants the only
// valid requester, or on a tie the one not served last (round-robin). The
// accepted operands are presented to the ALU from ISSUE onward, the result is
// captured after ALU_LAT WAIT cycles and held in RESP until the granted
// requester takes it.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   bus          alu_arbiter_if.slave, request/response channels
//   alu_a/alu_b  operands to the shared ALU
//   alu_func     function code to the shared ALU
//   alu_imm      immediate select, tied 0
//   alu_imm_val  immediate value, tied 0
//   alu_out      ALU result
//   alu_status   ALU status register
//   busy         high in every state except IDLE
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1     // legal range 1..7
) (
  input  logic             clk,
  input  logic             rst,
  alu_arbiter_if.slave     bus,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_func,
  output logic             alu_imm,
  output logic [WIDTH-1:0] alu_imm_val,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [7:0]       alu_status,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // WAIT runs from this value down to 0, i.e. exactly ALU_LAT cycles.
  localparam logic [2:0] WAIT_LOAD = 3'(ALU_LAT - 1);

  state_t     state;
  logic       grant;       // requester owning the in-flight operation
  logic       last_grant;  // requester served most recently
  logic [2:0] wait_cnt;

  logic pick;
  logic idle_open;
  logic accept;
  logic handshake;

  // Arbitration choice in IDLE: a lone requester wins, a tie goes to the
  // requester that was not served last.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    pick = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      pick = ~last_grant;
    end else if (bus.req1_valid) begin
      pick = 1'b1;
    end
  end

  // Outputs are forced low during reset, including the first reset cycle
  // before the synchronous reset has taken effect on the state register.
  assign idle_open      = (state == IDLE) && !rst;
  assign bus.req0_ready = idle_open && bus.req0_valid && !pick;
  assign bus.req1_ready = idle_open && bus.req1_valid &&  pick;
  assign bus.rsp0_valid = !rst && (state == RESP) && !grant;
  assign bus.rsp1_valid = !rst && (state == RESP) &&  grant;
  assign busy           = !rst && (state != IDLE);

  assign accept    = (bus.req0_valid && bus.req0_ready) ||
                     (bus.req1_valid && bus.req1_ready);
  assign handshake = (bus.rsp0_valid && bus.rsp0_ready) ||
                     (bus.rsp1_valid && bus.rsp1_ready);

  assign alu_imm     = 1'b0;
  assign alu_imm_val = '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      grant          <= 1'b0;
      last_grant     <= 1'b1;   // requester 0 wins the first tie
      wait_cnt       <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_func       <= '0;
      bus.rsp_data   <= '0;
      bus.rsp_status <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // The ALU operand registers double as the request latch, so they
            // carry the operation from ISSUE onward and hold afterwards.
            grant    <= pick;
            alu_a    <= pick ? bus.req1_a    : bus.req0_a;
            alu_b    <= pick ? bus.req1_b    : bus.req0_b;
            alu_func <= pick ? bus.req1_func : bus.req0_func;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= WAIT_LOAD;
          state    <= WAIT;
        end
        WAIT: begin
          if (wait_cnt == 3'd0) begin
            bus.rsp_data   <= alu_out;
            bus.rsp_status <= alu_status;
            state          <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        RESP: begin
          // No acceptance in the handshake cycle: IDLE is entered next cycle.
          if (handshake) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter -- directed bench for alu_arbiter with a behavioral
// one-cycle ALU (func 0 = a+b, otherwise a-b; status = {7'b0, zero}).
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_func;
  logic             alu_imm;
  logic [WIDTH-1:0] alu_imm_val;
  logic [WIDTH-1:0] alu_out;
  logic [7:0]       alu_status;
  logic             busy;

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(
    .WIDTH  (WIDTH),
    .ALU_LAT(1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_func   (alu_func),
    .alu_imm    (alu_imm),
    .alu_imm_val(alu_imm_val),
    .alu_out    (alu_out),
    .alu_status (alu_status),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Behavioral ALU, one register stage.
  logic [WIDTH-1:0] alu_res;
  assign alu_res = (alu_func == 4'd0) ? alu_a + alu_b : alu_a - alu_b;
  always @(posedge clk) begin
    alu_out    <= alu_res;
    alu_status <= {7'b0, (alu_res == '0)};
  end

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic rdy(input int i);
    return (i == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic rvld(input int i);
    return (i == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  task automatic set_req(input int i, input logic v, input int f, input int a, input int b);
    if (i == 0) begin
      bus.req0_valid = v; bus.req0_func = 4'(f); bus.req0_a = 16'(a); bus.req0_b = 16'(b);
    end else begin
      bus.req1_valid = v; bus.req1_func = 4'(f); bus.req1_a = 16'(a); bus.req1_b = 16'(b);
    end
  endtask

  task automatic set_rsp_ready(input int i, input logic v);
    if (i == 0) bus.rsp0_ready = v;
    else        bus.rsp1_ready = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve requester idx whose request is already being driven: wait for its
  // ready, check latency and result, optionally hold off the consumer, then
  // complete the handshake. Returns in the cycle after the handshake.
  task automatic serve(input int idx, input int exp_d, input int exp_s,
                       input int hold, output int t_acc);
    bit got;
    t_acc = -1;
    got   = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (rdy(idx)) begin
        got = 1;
        break;
      end
      tick();
    end
    check($sformatf("granted_%0d", idx), 32'(got), 1);
    if (!got) return;
    check($sformatf("ready_excl_%0d", idx), 32'(rdy(1 - idx)), 0);
    t_acc = cycle;
    tick();
    set_req(idx, 1'b0, 0, 0, 0);
    check("busy_issue", 32'(busy), 1);

    got = 0;
    for (int k = 0; k < 30; k++) begin
      if (rvld(idx)) begin
        got = 1;
        break;
      end
      tick();
    end
    check($sformatf("rsp_seen_%0d", idx), 32'(got), 1);
    if (!got) return;
    check("latency", 32'(cycle - t_acc), 3);
    check("rsp_data", 32'(bus.rsp_data), exp_d);
    check("rsp_status", 32'(bus.rsp_status), exp_s);
    check("rsp_other_low", 32'(rvld(1 - idx)), 0);

    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", 32'(rvld(idx)), 1);
      check("hold_data", 32'(bus.rsp_data), exp_d);
      check("hold_other_ready", 32'(rdy(1 - idx)), 0);
    end

    set_rsp_ready(idx, 1'b1);
    tick();
    set_rsp_ready(idx, 1'b0);
    check("busy_after_rsp", 32'(busy), 0);
  endtask

  int a0[4] = '{1, 2, 3, 4};
  int b0[4] = '{0, 2, 4, 6};
  int e0[4] = '{1, 4, 7, 10};
  int a1[4] = '{10, 11, 12, 13};
  int b1[4] = '{0, 1, 2, 3};
  int e1[4] = '{10, 12, 14, 16};

  initial begin
    int t;
    int t_prev;

    rst = 1'b1;
    set_req(0, 1'b1, 0, 0, 0);
    set_req(1, 1'b1, 0, 0, 0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;

    // Reset state, with both requesters valid.
    repeat (2) tick();
    check("rst_ready0", 32'(bus.req0_ready), 0);
    check("rst_ready1", 32'(bus.req1_ready), 0);
    check("rst_rsp0", 32'(bus.rsp0_valid), 0);
    check("rst_rsp1", 32'(bus.rsp1_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(bus.rsp_data), 0);
    check("rst_status", 32'(bus.rsp_status), 0);
    check("rst_alu_a", 32'(alu_a), 0);
    check("rst_alu_func", 32'(alu_func), 0);
    check("alu_imm", 32'(alu_imm), 0);
    check("alu_imm_val", 32'(alu_imm_val), 0);

    // Single operation: 4+3.
    rst = 1'b0;
    set_req(1, 1'b0, 0, 0, 0);
    set_req(0, 1'b1, 0, 4, 3);
    serve(0, 7, 8'h00, 0, t);

    // Tie right after reset: requester 0 first.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 0, 5, 5);
    set_req(1, 1'b1, 0, 2, 6);
    serve(0, 10, 8'h00, 0, t);
    serve(1, 8, 8'h00, 0, t);

    // Sustained contention: strict alternation, one op every 4 cycles.
    set_req(0, 1'b1, 0, a0[0], b0[0]);
    set_req(1, 1'b1, 0, a1[0], b1[0]);
    t_prev = 0;
    for (int k = 0; k < 8; k++) begin
      int idx;
      int n;
      idx = k % 2;
      n   = k / 2;
      serve(idx, (idx == 0) ? e0[n] : e1[n], 8'h00, 0, t);
      if (k > 0) check("throughput", 32'(t - t_prev), 4);
      t_prev = t;
      if (n < 3) begin
        if (idx == 0) set_req(0, 1'b1, 0, a0[n + 1], b0[n + 1]);
        else          set_req(1, 1'b1, 0, a1[n + 1], b1[n + 1]);
      end
    end

    // Backpressure on requester 0 while requester 1 waits.
    set_req(0, 1'b1, 0, 9, 1);
    set_req(1, 1'b1, 0, 7, 7);
    serve(0, 10, 8'h00, 5, t);
    serve(1, 14, 8'h00, 0, t);

    // Zero result sets the status zero flag.
    set_req(0, 1'b1, 0, 0, 0);
    serve(0, 0, 8'h01, 0, t);

    // Reset during WAIT aborts the operation.
    set_req(0, 1'b1, 0, 3, 3);
    #1;
    check("abort_ready", 32'(bus.req0_ready), 1);
    tick();
    set_req(0, 1'b0, 0, 0, 0);
    tick();
    check("abort_busy_wait", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("abort_busy_rst", 32'(busy), 0);
    check("abort_rsp0_rst", 32'(bus.rsp0_valid), 0);
    tick();
    check("abort_rsp0_after", 32'(bus.rsp0_valid), 0);
    check("abort_data", 32'(bus.rsp_data), 0);
    check("abort_alu_a", 32'(alu_a), 0);
    rst = 1'b0;
    set_req(1, 1'b1, 0, 1, 2);
    #1;
    check("abort_no_rsp0", 32'(bus.rsp0_valid), 0);
    check("abort_no_rsp1", 32'(bus.rsp1_valid), 0);
    serve(1, 3, 8'h00, 0, t);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
